// File: rtl/id_branch_hazard_ctrl_pkg.sv
// Shared constants for the ID-stage branch hazard controller: forwarding
// selects, FSM state encodings and the default worst-case stall depth.
package id_branch_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam int MAX_STALL_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/id_branch_hazard_ctrl_operand.sv
// Per-operand hazard check for the ID branch comparator: how many stall
// cycles the operand still needs, and which path should feed the comparator.
module branch_operand_hazard
    import id_branch_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 2
) (
    input  logic             i_used,
    input  logic [REG_W-1:0] i_idx,
    input  logic             i_ex_regwrite,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_mem_regwrite,
    input  logic             i_mem_memread,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_wb_regwrite,
    input  logic [REG_W-1:0] i_wb_rd,
    output logic [CNT_W-1:0] o_need,
    output logic [1:0]       o_fwd_sel
);

    logic w_live;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hardwired, so it never carries a hazard or a forward.
    assign w_live    = i_used && (i_idx != '0);
    assign w_ex_hit  = w_live && i_ex_regwrite  && (i_ex_rd  == i_idx);
    assign w_mem_hit = w_live && i_mem_regwrite && (i_mem_rd == i_idx);
    assign w_wb_hit  = w_live && i_wb_regwrite  && (i_wb_rd  == i_idx);

    always_comb begin
        o_need = '0;
        if (w_ex_hit) begin
            o_need = i_ex_memread ? CNT_W'(2) : CNT_W'(1);
        end else if (w_mem_hit && i_mem_memread) begin
            o_need = CNT_W'(1);
        end
    end

    // A load in MEM has no data on the EX/MEM path yet, so it cannot forward.
    always_comb begin
        o_fwd_sel = FWD_REGFILE;
        if (w_mem_hit && !i_mem_memread) begin
            o_fwd_sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_branch_hazard_ctrl.sv
// ID-stage conditional branch sequencer: stalls on comparator operand hazards,
// then resolves with forwarding. Optional counters under BRANCH_STATS_EN.
module id_branch_hazard_ctrl
    import id_branch_hazard_ctrl_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int CNT_W     = 2,
`ifdef BRANCH_STATS_EN
    parameter int STAT_W    = 32,
`endif
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic             i_id_is_branch,
    input  logic             i_id_uses_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_ex_regwrite,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_mem_regwrite,
    input  logic             i_mem_memread,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_wb_regwrite,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_branch_taken,
    input  logic             i_kill_id,
    output logic             o_stall_pc,
    output logic             o_stall_ifid,
    output logic             o_bubble_idex,
    output logic [1:0]       o_fwd_rs_sel,
    output logic [1:0]       o_fwd_rt_sel,
    output logic             o_br_resolve,
    output logic             o_redirect,
`ifdef BRANCH_STATS_EN
    output logic [STAT_W-1:0] o_stat_taken,
    output logic [STAT_W-1:0] o_stat_not_taken,
    output logic [STAT_W-1:0] o_stat_stall_cycles,
`endif
    output logic             o_flush_ifid
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_need_rs;
    logic [CNT_W-1:0] w_need_rt;
    logic [CNT_W-1:0] w_need_max;
    logic [CNT_W-1:0] w_need;
    logic [1:0]       w_fwd_rs;
    logic [1:0]       w_fwd_rt;
    logic             w_stall;
    logic             w_resolve;

    branch_operand_hazard #(.REG_W(REG_W), .CNT_W(CNT_W)) u_rs_hazard (
        .i_used         (1'b1),
        .i_idx          (i_id_rs),
        .i_ex_regwrite  (i_ex_regwrite),
        .i_ex_memread   (i_ex_memread),
        .i_ex_rd        (i_ex_rd),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_memread  (i_mem_memread),
        .i_mem_rd       (i_mem_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_rd        (i_wb_rd),
        .o_need         (w_need_rs),
        .o_fwd_sel      (w_fwd_rs)
    );

    branch_operand_hazard #(.REG_W(REG_W), .CNT_W(CNT_W)) u_rt_hazard (
        .i_used         (i_id_uses_rt),
        .i_idx          (i_id_rt),
        .i_ex_regwrite  (i_ex_regwrite),
        .i_ex_memread   (i_ex_memread),
        .i_ex_rd        (i_ex_rd),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_memread  (i_mem_memread),
        .i_mem_rd       (i_mem_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_rd        (i_wb_rd),
        .o_need         (w_need_rt),
        .o_fwd_sel      (w_fwd_rt)
    );

    assign w_need_max = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
    assign w_need     = (w_need_max > CNT_W'(MAX_STALL)) ? CNT_W'(MAX_STALL) : w_need_max;

    // A kill from a jump or exception overrides both stalling and resolving.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        w_resolve    = 1'b0;
        if (i_kill_id) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_id_valid && i_id_is_branch) begin
                        if (w_need == '0) begin
                            w_resolve = 1'b1;
                        end else begin
                            w_stall      = 1'b1;
                            w_next_state = ST_STALL;
                            w_next_cnt   = w_need - CNT_W'(1);
                        end
                    end
                end
                ST_STALL: begin
                    if (r_cnt != '0) begin
                        w_stall    = 1'b1;
                        w_next_cnt = r_cnt - CNT_W'(1);
                    end else begin
                        w_resolve    = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    assign o_stall_pc    = w_stall && i_rst_n;
    assign o_stall_ifid  = w_stall && i_rst_n;
    assign o_bubble_idex = w_stall && i_rst_n;
    assign o_br_resolve  = w_resolve && i_rst_n;
    assign o_fwd_rs_sel  = o_br_resolve ? w_fwd_rs : FWD_REGFILE;
    assign o_fwd_rt_sel  = o_br_resolve ? w_fwd_rt : FWD_REGFILE;
    assign o_redirect    = o_br_resolve && i_branch_taken;
    assign o_flush_ifid  = o_br_resolve && i_branch_taken;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] r_stat_taken;
    logic [STAT_W-1:0] r_stat_not_taken;
    logic [STAT_W-1:0] r_stat_stall_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_taken        <= '0;
            r_stat_not_taken    <= '0;
            r_stat_stall_cycles <= '0;
        end else begin
            if (o_br_resolve && i_branch_taken) begin
                r_stat_taken <= r_stat_taken + STAT_W'(1);
            end
            if (o_br_resolve && !i_branch_taken) begin
                r_stat_not_taken <= r_stat_not_taken + STAT_W'(1);
            end
            if (o_stall_pc) begin
                r_stat_stall_cycles <= r_stat_stall_cycles + STAT_W'(1);
            end
        end
    end

    assign o_stat_taken        = r_stat_taken;
    assign o_stat_not_taken    = r_stat_not_taken;
    assign o_stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule

// File: doc/id_branch_hazard_ctrl.md
Name: id_branch_hazard_ctrl

Overview:
- Sequences resolution of conditional branches (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ) in the ID stage of the 5-stage MIPS pipeline.
- Detects operand hazards on the branch comparator inputs, stalls IF/ID for the exact number of cycles a producer needs, then selects comparator forwarding paths.
- Consumes the taken decision from the ID branch checker and issues the PC redirect plus the IF/ID flush.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 2, stall counter width; must hold MAX_STALL.
- MAX_STALL, 2, worst-case stall cycles (a load in EX).
- STAT_W, 32, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_is_branch  in  1  ID instruction is a conditional branch (from jump control).
- id_uses_rt  in  1  branch compares rt (BEQ/BNE); 0 for the single-operand forms.
- id_rs, id_rt  in  REG_W  branch source register indices.
- ex_regwrite, ex_memread  in  1  EX-stage write enable / load flag.
- ex_rd  in  REG_W  EX destination register.
- mem_regwrite, mem_memread  in  1  MEM-stage write enable / load flag.
- mem_rd  in  REG_W  MEM destination register.
- wb_regwrite  in  1  WB write enable.
- wb_rd  in  REG_W  WB destination register.
- branch_taken  in  1  comparator result, valid only in the resolve cycle.
- kill_id  in  1  higher-priority flush of ID (jump/exception).
- stall_pc, stall_ifid  out  1  hold PC and the IF/ID register.
- bubble_idex  out  1  insert a NOP into ID/EX.
- fwd_rs_sel, fwd_rt_sel  out  2  comparator source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data.
- br_resolve  out  1  branch resolves this cycle.
- redirect  out  1  load the branch target into PC.
- flush_ifid  out  1  squash the fetched slot.

Behaviour:
- States: IDLE, STALL. A 2-state FSM plus a down-counter cnt (CNT_W).
- Per-operand need (rt counted only if id_uses_rt; index 0 always needs 0):
  - EX load match: 2.
  - EX ALU match: 1.
  - MEM load match: 1.
  - Otherwise: 0.
- need = max(rs_need, rt_need).
- IDLE, with id_valid & id_is_branch & ~kill_id:
  - need==0: resolve this cycle.
  - need>0: assert stall_pc, stall_ifid and bubble_idex combinationally; load cnt=need-1; go to STALL.
- STALL:
  - cnt!=0: keep stalling and decrement cnt.
  - cnt==0: drop the stalls, resolve, return to IDLE.
- Stall cycles per hazard:
  - EX load: exactly 2.
  - EX ALU: 1.
  - MEM load: 1.
- Resolve cycle:
  - br_resolve=1.
  - fwd_*_sel priority: MEM match (01, non-load) over WB match (10) over regfile (00); index 0 always selects 00.
  - redirect = flush_ifid = branch_taken. These are single-cycle pulses; no branch_taken sampling in any other cycle.
- kill_id in any state: all outputs 0 this cycle, next state IDLE, cnt=0. kill_id wins over resolve.
- Non-branch or invalid ID: all outputs 0, and the FSM stays in IDLE.
- Reset (asynchronous, mid-stall included): state=IDLE, cnt=0. All outputs evaluate to 0 while rst_n=0.
- Outputs are Mealy, with no registered latency; stall asserts in the same cycle the hazard is seen.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds output ports stat_taken, stat_not_taken and stat_stall_cycles (each STAT_W).
  - Taken/not-taken increment on each resolve cycle.
  - stall_cycles increments on every cycle stall_pc=1.
  - All three reset to 0 asynchronously and wrap modulo 2^STAT_W.
- When undefined, the ports and counters are absent; functionality is otherwise identical.

Decomposition:
- Shared package: the FWD_REGFILE/FWD_EXMEM/FWD_MEMWB 2-bit constants, the state encodings (IDLE=0, STALL=1), and the MAX_STALL default.
- Opcode defines stay in the existing definitions header.
- One natural sub-module: branch_operand_hazard. It is instantiated twice (rs, rt) and returns the need count and forward select for one operand.

Test Plan:
- BEQ rs=8 with EX lw rd=8 → stall_pc high for exactly 2 cycles. 3rd cycle: br_resolve=1, fwd_rs_sel=10. Taken → redirect and flush_ifid pulse 1 cycle.
- BNE rs=3, rt=4 with EX add rd=4 → 1 stall cycle, then fwd_rt_sel=01 and fwd_rs_sel=00. Not taken → redirect=0.
- BGTZ rs=0 with EX lw rd=0 → no stall, resolve immediately, fwd_rs_sel=00.
- BLEZ (id_uses_rt=0), rt=5, EX lw rd=5 → no stall.
- EX-load hazard, kill_id asserted in the 1st STALL cycle → outputs 0, IDLE next cycle. Likewise, rst_n pulsed low mid-stall → IDLE, cnt=0, no redirect.
- With BRANCH_STATS_EN: 3 branches (taken, not-taken, taken with 2 stalls) → stat_taken=2, stat_not_taken=1, stat_stall_cycles=2.
